xcorr_lag: RTL and testbench



---
 rtl/xcorr_lag_pkg.sv | 18 +
 rtl/xcorr_lag_match_count.sv | 28 ++
 rtl/xcorr_lag.sv | 156 +++++++++++++++
 tb/tb_xcorr_lag.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xcorr_lag_pkg.sv
`default_nettype none
// ============================================================================
// Module      : xcorr_lag_pkg
// Description : Shared constants and FSM encoding for the circular lag estimator
// Revision    : 1.0 - initial release
// ============================================================================
package xcorr_lag_pkg;

    localparam int c_NDATA_DEFAULT = 128;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/xcorr_lag_match_count.sv
`default_nettype none
// ============================================================================
// Module      : match_count
// Description : Combinational count of bit positions where two vectors agree
// Revision    : 1.0 - initial release
// ============================================================================
module match_count #(
    parameter int  NDATA     = 128,
    localparam int NDATA_LOG = $clog2(NDATA)
) (
    input  logic [NDATA-1:0]   vec_a,
    input  logic [NDATA-1:0]   vec_b,
    output logic [NDATA_LOG:0] count
);

    logic [NDATA-1:0] w_eq;

    assign w_eq = ~(vec_a ^ vec_b);

    always_comb begin
        count = '0;
        for (int i = 0; i < NDATA; i++) begin
            count = count + {{NDATA_LOG{1'b0}}, w_eq[i]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/xcorr_lag.sv
`default_nettype none
// ============================================================================
// Module      : xcorr_lag
// Description : Circular cross-correlation lag sweep; best lag/score per channel
// Revision    : 1.0 - initial release
// ============================================================================
module xcorr_lag
    import xcorr_lag_pkg::*;
#(
    parameter int  NDATA     = c_NDATA_DEFAULT,
    localparam int NDATA_LOG = $clog2(NDATA)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [NDATA-1:0]     dinRef,
    input  logic [NDATA-1:0]     dinSigA,
    input  logic [NDATA-1:0]     dinSigB,
    input  logic [NDATA-1:0]     dinSigC,
    output logic                 busy,
    output logic                 done,
    output logic [NDATA_LOG-1:0] lagA,
    output logic [NDATA_LOG-1:0] lagB,
    output logic [NDATA_LOG-1:0] lagC,
    output logic [NDATA_LOG:0]   scoreA,
    output logic [NDATA_LOG:0]   scoreB,
    output logic [NDATA_LOG:0]   scoreC
);

    localparam int                   c_NCH    = 3;
    localparam logic [NDATA_LOG-1:0] c_K_LAST = NDATA_LOG'(NDATA - 1);
    localparam logic [NDATA_LOG-1:0] c_K_ONE  = NDATA_LOG'(1);

    state_t r_state;
    state_t w_state_nxt;

    logic [NDATA-1:0]     r_ref;
    logic [NDATA-1:0]     r_sig        [c_NCH];
    logic [NDATA-1:0]     w_din        [c_NCH];
    logic [NDATA_LOG-1:0] r_k;
    logic [NDATA_LOG:0]   w_score      [c_NCH];
    logic [NDATA_LOG:0]   r_best_score [c_NCH];
    logic [NDATA_LOG:0]   w_nxt_score  [c_NCH];
    logic [NDATA_LOG-1:0] r_best_lag   [c_NCH];
    logic [NDATA_LOG-1:0] w_nxt_lag    [c_NCH];
    logic [NDATA_LOG:0]   r_score_out  [c_NCH];
    logic [NDATA_LOG-1:0] r_lag_out    [c_NCH];
    logic                 w_last;

    assign w_din[0] = dinSigA;
    assign w_din[1] = dinSigB;
    assign w_din[2] = dinSigC;
    assign w_last   = (r_k == c_K_LAST);

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start)  w_state_nxt = ST_RUN;
            ST_RUN:  if (w_last) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign busy = (r_state != ST_IDLE);
    assign done = (r_state == ST_DONE);

    // ------------------------------------------------------------------------
    // Per-channel scoring and best-so-far selection
    // ------------------------------------------------------------------------
    for (genvar ch = 0; ch < c_NCH; ch++) begin : g_ch
        match_count #(
            .NDATA (NDATA)
        ) u_match_count (
            .vec_a (r_ref),
            .vec_b (r_sig[ch]),
            .count (w_score[ch])
        );

        // Strict compare keeps the earliest lag on ties.
        always_comb begin
            w_nxt_score[ch] = r_best_score[ch];
            w_nxt_lag[ch]   = r_best_lag[ch];
            if (w_score[ch] > r_best_score[ch]) begin
                w_nxt_score[ch] = w_score[ch];
                w_nxt_lag[ch]   = r_k;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Datapath: shadows, rotation, lag counter, trackers, result registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ref <= '0;
            r_k   <= '0;
            for (int ch = 0; ch < c_NCH; ch++) begin
                r_sig[ch]        <= '0;
                r_best_score[ch] <= '0;
                r_best_lag[ch]   <= '0;
                r_score_out[ch]  <= '0;
                r_lag_out[ch]    <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_ref <= dinRef;
                        r_k   <= '0;
                        for (int ch = 0; ch < c_NCH; ch++) begin
                            r_sig[ch]        <= w_din[ch];
                            r_best_score[ch] <= '0;
                            r_best_lag[ch]   <= '0;
                        end
                    end
                end
                ST_RUN: begin
                    r_k <= r_k + c_K_ONE;
                    for (int ch = 0; ch < c_NCH; ch++) begin
                        r_best_score[ch] <= w_nxt_score[ch];
                        r_best_lag[ch]   <= w_nxt_lag[ch];
                        r_sig[ch]        <= {r_sig[ch][0], r_sig[ch][NDATA-1:1]};
                        // Results land on the edge into DONE so they are
                        // already valid while done is high.
                        if (w_last) begin
                            r_score_out[ch] <= w_nxt_score[ch];
                            r_lag_out[ch]   <= w_nxt_lag[ch];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign lagA   = r_lag_out[0];
    assign lagB   = r_lag_out[1];
    assign lagC   = r_lag_out[2];
    assign scoreA = r_score_out[0];
    assign scoreB = r_score_out[1];
    assign scoreC = r_score_out[2];

endmodule
`default_nettype wire

// File: tb/tb_xcorr_lag.sv
`default_nettype none
// ============================================================================
// Module      : tb_xcorr_lag
// Description : Self-checking bench for xcorr_lag with a result scoreboard
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xcorr_lag;

    localparam int N = 128;
    localparam int L = 7;

    typedef struct {
        int lag   [3];
        int score [3];
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [N-1:0] dinRef = '0;
    logic [N-1:0] dinSigA = '0;
    logic [N-1:0] dinSigB = '0;
    logic [N-1:0] dinSigC = '0;
    logic         busy;
    logic         done;
    logic [L-1:0] lagA, lagB, lagC;
    logic [L:0]   scoreA, scoreB, scoreC;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    xcorr_lag #(.NDATA(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .dinRef  (dinRef),
        .dinSigA (dinSigA),
        .dinSigB (dinSigB),
        .dinSigC (dinSigC),
        .busy    (busy),
        .done    (done),
        .lagA    (lagA),
        .lagB    (lagB),
        .lagC    (lagC),
        .scoreA  (scoreA),
        .scoreB  (scoreB),
        .scoreC  (scoreC)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] rand_vec();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // sig[(i+d) % N] = r[i]
    function automatic logic [N-1:0] shift_vec(input logic [N-1:0] r, input int d);
        logic [N-1:0] s;
        for (int i = 0; i < N; i++) s[(i + d) % N] = r[i];
        return s;
    endfunction

    function automatic logic [N-1:0] mask_ones(input int cnt);
        logic [N-1:0] m;
        m = '0;
        while ($countones(m) < cnt) m[$urandom_range(N - 1, 0)] = 1'b1;
        return m;
    endfunction

    // Direct evaluation of the score definition over all lags.
    function automatic void best_of(input logic [N-1:0] r, input logic [N-1:0] s,
                                    output int lag, output int score);
        lag   = 0;
        score = 0;
        for (int k = 0; k < N; k++) begin
            int c;
            c = 0;
            for (int i = 0; i < N; i++) if (r[i] == s[(i + k) % N]) c++;
            if (c > score) begin
                score = c;
                lag   = k;
            end
        end
    endfunction

    task automatic launch(input logic [N-1:0] r, input logic [N-1:0] a,
                          input logic [N-1:0] b, input logic [N-1:0] c);
        exp_t e;
        @(negedge clk);
        dinRef  = r;
        dinSigA = a;
        dinSigB = b;
        dinSigC = c;
        start   = 1'b1;
        best_of(r, a, e.lag[0], e.score[0]);
        best_of(r, b, e.lag[1], e.score[1]);
        best_of(r, c, e.lag[2], e.score[2]);
        sb.push_back(e);
    endtask

    // Waits for done after a launch; protocol mode pokes start and inputs mid-sweep.
    task automatic await_result(input string tag, input bit protocol);
        int   cyc;
        bit   seen;
        exp_t e;
        int   got_lag   [3];
        int   got_score [3];
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                n_vec++;
                if (busy !== 1'b1) begin
                    n_err++;
                    $display("FAIL %s busy_at_run: got %b expected 1", tag, busy);
                end
            end
            if (done === 1'b1) begin
                seen = 1'b1;
                n_vec++;
                if (cyc != N + 1) begin
                    n_err++;
                    $display("FAIL %s done_latency: got %0d expected %0d", tag, cyc, N + 1);
                end
                e = sb.pop_front();
                got_lag[0]   = int'(lagA);
                got_lag[1]   = int'(lagB);
                got_lag[2]   = int'(lagC);
                got_score[0] = int'(scoreA);
                got_score[1] = int'(scoreB);
                got_score[2] = int'(scoreC);
                for (int ch = 0; ch < 3; ch++) begin
                    n_vec++;
                    if (got_lag[ch] !== e.lag[ch]) begin
                        n_err++;
                        $display("FAIL %s lag[%0d]: got %0d expected %0d", tag, ch, got_lag[ch], e.lag[ch]);
                    end
                    n_vec++;
                    if (got_score[ch] !== e.score[ch]) begin
                        n_err++;
                        $display("FAIL %s score[%0d]: got %0d expected %0d", tag, ch, got_score[ch], e.score[ch]);
                    end
                end
            end
            if (protocol) begin
                start = (cyc == 1 || cyc == 60 || cyc == N + 1);
                if (cyc == 2) begin
                    dinRef  = rand_vec();
                    dinSigA = rand_vec();
                    dinSigB = rand_vec();
                    dinSigC = rand_vec();
                end
            end else begin
                start = 1'b0;
            end
        end
        if (!seen) begin
            n_vec++;
            n_err++;
            $display("FAIL %s done_timeout: got no done expected done at %0d", tag, N + 1);
            if (sb.size() > 0) void'(sb.pop_front());
        end
    endtask

    task automatic check_cleared(input string tag);
        n_vec++;
        if ({busy, done} !== 2'b00) begin
            n_err++;
            $display("FAIL %s busy_done: got %b expected 00", tag, {busy, done});
        end
        n_vec++;
        if ({lagA, lagB, lagC, scoreA, scoreB, scoreC} !== '0) begin
            n_err++;
            $display("FAIL %s outputs: got %0h expected 0", tag,
                     {lagA, lagB, lagC, scoreA, scoreB, scoreC});
        end
    endtask

    task automatic no_done_for(input string tag, input int cycles);
        int hits;
        hits = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done !== 1'b0) hits++;
        end
        n_vec++;
        if (hits != 0) begin
            n_err++;
            $display("FAIL %s spurious_done: got %0d pulses expected 0", tag, hits);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            dinRef  = rand_vec();
            dinSigA = rand_vec();
            dinSigB = rand_vec();
            dinSigC = rand_vec();
            start   = 1'b1;
        end
        @(negedge clk);
        check_cleared("reset");
        rst   = 1'b0;
        start = 1'b0;
        no_done_for("reset", 200);
    endtask

    task automatic test_identity();
        logic [N-1:0] r;
        r = rand_vec();
        launch(r, r, r, r);
        await_result("identity", 1'b0);
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL identity busy_after_done: got %b expected 0", busy);
        end
    endtask

    task automatic test_known_shifts();
        logic [N-1:0] r;
        r = rand_vec();
        launch(r, shift_vec(r, 5), shift_vec(r, 127), shift_vec(r, 64) ^ mask_ones(10));
        await_result("shifts", 1'b0);
    endtask

    task automatic test_tie();
        launch(mask_ones(40), rand_vec(), rand_vec(), '0);
        await_result("tie", 1'b0);
    endtask

    task automatic test_protocol();
        logic [N-1:0] r;
        r = rand_vec();
        launch(r, shift_vec(r, 17), ~shift_vec(r, 3), shift_vec(r, 100));
        await_result("protocol", 1'b1);
        r = rand_vec();
        launch(r, shift_vec(r, 33), r, shift_vec(r, 1));
        await_result("restart", 1'b0);
    endtask

    task automatic test_abort();
        logic [N-1:0] r;
        r = rand_vec();
        launch(r, r, r, r);
        for (int c = 1; c < 50; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_cleared("abort");
        rst = 1'b0;
        void'(sb.pop_front());
        no_done_for("abort", 200);
        r = rand_vec();
        launch(r, shift_vec(r, 9), shift_vec(r, 90), rand_vec());
        await_result("after_abort", 1'b0);
    endtask

    initial begin
        test_reset();
        test_identity();
        test_known_shifts();
        test_tie();
        test_protocol();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
